// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one
// transaction at a time, with LS priority and a starvation limit for IF.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_MemRW,
  input  logic [2:0]        ls_funct3,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_ack,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              mem_en,
  output logic              mem_MemRW,
  output logic [2:0]        mem_funct3,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_err,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_LS} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t     state, state_next;
  logic [3:0] starve_cnt, starve_next;
  logic       if_elig, ls_elig;
  logic       grant_if, grant_ls;
  logic       accept, spurious;

  // A requester is blind to its own req during its ack cycle, so a held req
  // is read as a new request only from the following cycle.
  assign if_elig  = if_req && !if_ack;
  assign ls_elig  = ls_req && !ls_ack;
  assign busy     = (state != IDLE);
  // mem_en marks the first BUSY cycle; a response there is too early to be real.
  assign accept   = busy && !mem_en && mem_rvalid;
  assign spurious = mem_rvalid && (!busy || mem_en);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else begin
      state      <= state_next;
      starve_cnt <= starve_next;
    end
  end

  always_comb begin
    state_next  = state;
    starve_next = starve_cnt;
    grant_if    = 1'b0;
    grant_ls    = 1'b0;
    case (state)
      IDLE: begin
        if (if_elig && (!ls_elig || starve_cnt == STARVE_LIM)) begin
          grant_if    = 1'b1;
          state_next  = BUSY_IF;
          starve_next = '0;
        end else if (ls_elig) begin
          grant_ls   = 1'b1;
          state_next = BUSY_LS;
          if (if_elig && starve_cnt != STARVE_LIM)
            starve_next = starve_cnt + 4'd1;
        end
      end
      BUSY_IF, BUSY_LS: begin
        if (accept)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_en     <= 1'b0;
      mem_MemRW  <= 1'b1;
      mem_funct3 <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_ack     <= 1'b0;
      ls_ack     <= 1'b0;
      if_rdata   <= '0;
      ls_rdata   <= '0;
      mem_err    <= 1'b0;
    end else begin
      mem_en <= grant_if || grant_ls;
      if_ack <= accept && (state == BUSY_IF);
      ls_ack <= accept && (state == BUSY_LS);
      if (grant_if) begin
        mem_addr   <= if_addr;
        mem_MemRW  <= 1'b1;
        mem_funct3 <= 3'b010;
        mem_wdata  <= '0;
      end else if (grant_ls) begin
        mem_addr   <= ls_addr;
        mem_MemRW  <= ls_MemRW;
        mem_funct3 <= ls_funct3;
        mem_wdata  <= ls_wdata;
      end
      if (accept && state == BUSY_IF)
        if_rdata <= mem_rdata;
      // Stores leave ls_rdata untouched so the last load value survives.
      if (accept && state == BUSY_LS && mem_MemRW)
        ls_rdata <= mem_rdata;
      if (spurious)
        mem_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, hand-written corner
// sequences, and a scoreboard of expected transactions checked by a monitor.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        ls_req;
  logic        ls_MemRW;
  logic [2:0]  ls_funct3;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_ack;
  logic [31:0] ls_rdata;
  logic        mem_en;
  logic        mem_MemRW;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_err;
  logic        busy;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_MemRW(ls_MemRW), .ls_funct3(ls_funct3),
    .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_ack(ls_ack), .ls_rdata(ls_rdata),
    .mem_en(mem_en), .mem_MemRW(mem_MemRW), .mem_funct3(mem_funct3),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .mem_err(mem_err), .busy(busy)
  );

  typedef struct {
    bit          is_ls;
    logic        rw;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  typedef struct {
    bit          is_ls;
    logic        rw;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic        e_rw;
    logic [2:0]  e_f3;
    logic [31:0] e_wdata;
    logic [31:0] e_rdata;
    int          e_cycles;
  } vec_t;

  exp_t        exp_q[$];
  vec_t        vecs[8];
  int          check_cnt = 0;
  int          pass_cnt  = 0;
  bit          auto_mem  = 1'b1;
  int          mem_lat   = 1;
  logic [31:0] last_load = 32'h0;
  bit          prev_busy = 1'b0;
  logic        auto_rvalid = 1'b0;
  logic [31:0] auto_rdata  = 32'h0;
  logic        man_rvalid  = 1'b0;
  logic [31:0] man_rdata   = 32'h0;

  assign mem_rvalid = auto_rvalid | man_rvalid;
  assign mem_rdata  = man_rvalid ? man_rdata : auto_rdata;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] memData(input logic [31:0] addr);
    if (addr == 32'h0000_0100) return 32'h00A0_0093;
    return (addr ^ 32'h5A5A_0000) + 32'h11;
  endfunction

  function automatic exp_t ifExp(input logic [31:0] addr);
    exp_t e;
    e = '{1'b0, 1'b1, 3'b010, addr, 32'h0, memData(addr)};
    return e;
  endfunction

  // Loads update the remembered load value; stores expect it to be held.
  function automatic exp_t lsExp(input logic rw, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata);
    exp_t e;
    e = '{1'b1, rw, f3, addr, wdata, rw ? memData(addr) : last_load};
    if (rw) last_load = memData(addr);
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    check_cnt++;
    if (act === req) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, act, req);
  endtask

  task automatic applyStimulus(input bit is_ls, input logic rw, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wdata, input exp_t e);
    exp_q.push_back(e);
    if (is_ls) begin
      ls_MemRW  = rw;
      ls_funct3 = f3;
      ls_addr   = addr;
      ls_wdata  = wdata;
      ls_req    = 1'b1;
    end else begin
      if_addr = addr;
      if_req  = 1'b1;
    end
  endtask

  // sel: 0 = mem_en, 1 = if_ack, 2 = ls_ack; n = negedges waited, 0 on timeout.
  task automatic waitSignal(input int sel, output int n);
    n = 0;
    for (int c = 1; c <= 64; c++) begin
      @(negedge clk);
      if ((sel == 0 && mem_en) || (sel == 1 && if_ack) || (sel == 2 && ls_ack)) begin
        n = c;
        break;
      end
    end
    if (n == 0) checkOutput($sformatf("timeout_sel%0d", sel), 32'(n), 32'd1);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_if_ack"},     32'(if_ack),     32'd0);
    checkOutput({tag, "_ls_ack"},     32'(ls_ack),     32'd0);
    checkOutput({tag, "_if_rdata"},   if_rdata,        32'd0);
    checkOutput({tag, "_ls_rdata"},   ls_rdata,        32'd0);
    checkOutput({tag, "_mem_en"},     32'(mem_en),     32'd0);
    checkOutput({tag, "_mem_MemRW"},  32'(mem_MemRW),  32'd1);
    checkOutput({tag, "_mem_funct3"}, 32'(mem_funct3), 32'd0);
    checkOutput({tag, "_mem_addr"},   mem_addr,        32'd0);
    checkOutput({tag, "_mem_wdata"},  mem_wdata,       32'd0);
    checkOutput({tag, "_mem_err"},    32'(mem_err),    32'd0);
    checkOutput({tag, "_busy"},       32'(busy),       32'd0);
  endtask

  task automatic applyReset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkResetOutputs("reset");
    exp_q.delete();
    last_load = 32'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Memory model: answers each mem_en after mem_lat cycles with memData(addr).
  initial begin
    forever begin
      @(negedge clk);
      if (auto_mem && rst_n && mem_en) begin
        repeat (mem_lat) @(negedge clk);
        auto_rvalid = 1'b1;
        auto_rdata  = memData(mem_addr);
        @(negedge clk);
        auto_rvalid = 1'b0;
      end
    end
  end

  // Scoreboard monitor: grant fields held through BUSY, acks popped in order.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_busy = 1'b0;
      end else begin
        checkOutput("single_ack", 32'(if_ack && ls_ack), 32'd0);
        checkOutput("mem_en_first_busy", 32'(mem_en), 32'(busy && !prev_busy));
        if (busy) begin
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_busy", 32'(busy), 32'd0);
          end else begin
            checkOutput("mem_addr", mem_addr, exp_q[0].addr);
            checkOutput("mem_wdata", mem_wdata, exp_q[0].wdata);
            checkOutput("mem_ctl", 32'({mem_MemRW, mem_funct3}), 32'({exp_q[0].rw, exp_q[0].f3}));
          end
        end
        if (if_ack || ls_ack) begin
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_ack", 32'({if_ack, ls_ack}), 32'd0);
          end else begin
            e = exp_q.pop_front();
            checkOutput("ack_owner", 32'(ls_ack), 32'(e.is_ls));
            checkOutput("ack_rdata", ls_ack ? ls_rdata : if_rdata, e.rdata);
          end
        end
        prev_busy = busy;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_t e;
    int   n;
    int   ls_done, if_done;
    bit   ls_pause, if_pause;

    rst_n = 1'b0; if_req = 1'b0; if_addr = '0; ls_req = 1'b0; ls_MemRW = 1'b0;
    ls_funct3 = '0; ls_addr = '0; ls_wdata = '0;

    vecs[0] = '{1'b0, 1'b1, 3'b000, 32'h0000_0100, 32'h0, 1, 1'b1, 3'b010, 32'h0, 32'h00A0_0093, 3};
    vecs[1] = '{1'b1, 1'b0, 3'b000, 32'h0000_2004, 32'hDEAD_BEEF, 4, 1'b0, 3'b000, 32'hDEAD_BEEF, 32'h0, 6};
    vecs[2] = '{1'b1, 1'b1, 3'b010, 32'h0000_2008, 32'h5555_5555, 1, 1'b1, 3'b010, 32'h5555_5555, memData(32'h2008), 3};
    vecs[3] = '{1'b1, 1'b0, 3'b001, 32'h0000_200C, 32'h1234_5678, 2, 1'b0, 3'b001, 32'h1234_5678, memData(32'h2008), 4};
    vecs[4] = '{1'b0, 1'b0, 3'b111, 32'h0000_0104, 32'hFFFF_FFFF, 3, 1'b1, 3'b010, 32'h0, memData(32'h104), 5};
    vecs[5] = '{1'b1, 1'b1, 3'b100, 32'h0000_3000, 32'h0, 2, 1'b1, 3'b100, 32'h0, memData(32'h3000), 4};
    vecs[6] = '{1'b0, 1'b1, 3'b000, 32'hFFFF_FFFC, 32'h0, 1, 1'b1, 3'b010, 32'h0, memData(32'hFFFF_FFFC), 3};
    vecs[7] = '{1'b1, 1'b0, 3'b111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1'b0, 3'b111, 32'hFFFF_FFFF, memData(32'h3000), 3};

    repeat (2) @(negedge clk);
    checkResetOutputs("por");
    rst_n = 1'b1;
    @(negedge clk);

    // Table: one requester at a time, varied latency, loads and stores.
    for (int i = 0; i < 8; i++) begin
      mem_lat = vecs[i].lat;
      e = '{vecs[i].is_ls, vecs[i].e_rw, vecs[i].e_f3, vecs[i].addr, vecs[i].e_wdata, vecs[i].e_rdata};
      if (vecs[i].is_ls && vecs[i].rw) last_load = vecs[i].e_rdata;
      applyStimulus(vecs[i].is_ls, vecs[i].rw, vecs[i].f3, vecs[i].addr, vecs[i].wdata, e);
      waitSignal(vecs[i].is_ls ? 2 : 1, n);
      checkOutput($sformatf("vec%0d_latency", i), 32'(n), 32'(vecs[i].e_cycles));
      if_req = 1'b0;
      ls_req = 1'b0;
      @(negedge clk);
    end
    checkOutput("no_err_after_table", 32'(mem_err), 32'd0);

    // Response in the mem_en cycle is spurious; the real one a cycle later completes.
    auto_mem = 1'b0;
    applyStimulus(1'b0, 1'b1, 3'b010, 32'h0000_0180, 32'h0, ifExp(32'h180));
    waitSignal(0, n);
    man_rvalid = 1'b1;
    man_rdata  = 32'hBAD0_BAD0;
    @(negedge clk);
    checkOutput("early_rvalid_err", 32'(mem_err), 32'd1);
    checkOutput("early_rvalid_busy", 32'(busy), 32'd1);
    checkOutput("early_rvalid_no_ack", 32'(if_ack), 32'd0);
    man_rdata = memData(32'h180);
    @(negedge clk);
    man_rvalid = 1'b0;
    checkOutput("early_rvalid_then_ack", 32'(if_ack), 32'd1);
    if_req = 1'b0;
    applyReset();

    // Response while IDLE: flag only, no state change.
    man_rvalid = 1'b1;
    man_rdata  = 32'h1111_2222;
    @(negedge clk);
    man_rvalid = 1'b0;
    checkOutput("idle_rvalid_err", 32'(mem_err), 32'd1);
    checkOutput("idle_rvalid_busy", 32'(busy), 32'd0);
    @(negedge clk);
    checkOutput("idle_rvalid_still_idle", 32'(busy), 32'd0);
    auto_mem = 1'b1;
    mem_lat  = 1;
    applyStimulus(1'b1, 1'b1, 3'b010, 32'h0000_2100, 32'h0, lsExp(1'b1, 3'b010, 32'h2100, 32'h0));
    waitSignal(2, n);
    ls_req = 1'b0;
    checkOutput("err_sticky", 32'(mem_err), 32'd1);
    @(negedge clk);

    // Collision: each requester stands aside during the other's ack cycle, so
    // every arbitration sees both; order must be LS,LS,LS,IF twice.
    for (int k = 0; k < 8; k++) begin
      if (k == 3)      exp_q.push_back(ifExp(32'h400));
      else if (k == 7) exp_q.push_back(ifExp(32'h404));
      else             exp_q.push_back(lsExp(1'b1, 3'b010, 32'h3100 + 32'(4 * (k > 3 ? k - 1 : k)), 32'h0));
    end
    ls_done = 0; if_done = 0;
    ls_MemRW = 1'b1; ls_funct3 = 3'b010; ls_addr = 32'h3100; ls_wdata = 32'h0;
    if_addr = 32'h400;
    ls_req = 1'b1; if_req = 1'b1;
    for (int c = 0; c < 200 && (ls_done < 6 || if_done < 2); c++) begin
      @(negedge clk);
      ls_pause = 1'b0;
      if_pause = 1'b0;
      if (ls_ack) begin ls_done++; if_pause = 1'b1; ls_addr = 32'h3100 + 32'(4 * ls_done); end
      if (if_ack) begin if_done++; ls_pause = 1'b1; if_addr = 32'h400 + 32'(4 * if_done); end
      ls_req = (ls_done < 6) && !ls_pause;
      if_req = (if_done < 2) && !if_pause;
    end
    ls_req = 1'b0; if_req = 1'b0;
    @(negedge clk);
    checkOutput("collision_ls_count", 32'(ls_done), 32'd6);
    checkOutput("collision_if_count", 32'(if_done), 32'd2);
    checkOutput("collision_queue_empty", 32'(exp_q.size()), 32'd0);

    // Ack masking: ls_req dropped a cycle late; the waiting IF wins in the ls_ack cycle.
    applyStimulus(1'b1, 1'b1, 3'b000, 32'h0000_2200, 32'h0, lsExp(1'b1, 3'b000, 32'h2200, 32'h0));
    waitSignal(0, n);
    applyStimulus(1'b0, 1'b1, 3'b010, 32'h0000_0240, 32'h0, ifExp(32'h240));
    waitSignal(2, n);
    @(negedge clk);
    checkOutput("mask_if_granted", 32'(mem_en), 32'd1);
    ls_req = 1'b0;
    waitSignal(1, n);
    if_req = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("mask_idle_after", 32'(busy), 32'd0);
    checkOutput("mask_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset during BUSY_LS abandons the load; its late response flags mem_err.
    auto_mem = 1'b0;
    applyStimulus(1'b1, 1'b1, 3'b010, 32'h0000_2300, 32'h0, lsExp(1'b1, 3'b010, 32'h2300, 32'h0));
    waitSignal(0, n);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkResetOutputs("midreset");
    exp_q.delete();
    last_load = 32'h0;
    ls_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    man_rvalid = 1'b1;
    man_rdata  = 32'hCAFE_0000;
    @(negedge clk);
    man_rvalid = 1'b0;
    checkOutput("late_rvalid_err", 32'(mem_err), 32'd1);
    checkOutput("late_rvalid_idle", 32'(busy), 32'd0);
    auto_mem = 1'b1;
    mem_lat  = 1;
    applyStimulus(1'b0, 1'b1, 3'b010, 32'h0000_0300, 32'h0, ifExp(32'h300));
    waitSignal(1, n);
    checkOutput("post_reset_fetch_latency", 32'(n), 32'd3);
    if_req = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
